// File: rtl/hazard_pkg.sv
// Shared types for the hazard / pipeline-control unit: FSM states,
// the register-file forward select code and the scoreboard entry layout.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam int FWD_RF = 0;

  // Widest register address the scoreboard entry can hold; narrower
  // addresses are zero-extended into it.
  localparam int SB_RD_W = 8;
  typedef logic [SB_RD_W-1:0] sb_rd_t;

  typedef struct packed {
    logic   valid;
    sb_rd_t rd;
    logic   is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard (stage 0 = execute) with the
// youngest-producer-wins forward select logic for both execute operands.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int FWD_STAGES = 2,
  localparam int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  enter,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  wr_enable,
  input  logic                  is_load,
  output sb_entry_t             head,
  output logic [FWD_SEL_W-1:0]  fwd_sel_a,
  output logic [FWD_SEL_W-1:0]  fwd_sel_b
);

  sb_entry_t             sb [FWD_STAGES+1];
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this array is a handful of flops, not RAM, and stale valid bits
      // would forward garbage after reset, so every entry is cleared.
      for (int k = 0; k <= FWD_STAGES; k++) sb[k] <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let each stage take its neighbour's
      // pre-edge value regardless of loop order.
      for (int k = FWD_STAGES; k >= 1; k--) sb[k] <= sb[k-1];
      sb[0].valid   <= enter && wr_enable && (rd != '0);
      sb[0].rd      <= sb_rd_t'(rd);
      sb[0].is_load <= enter && is_load;
      ex_rs1        <= enter ? rs1 : '0;
      ex_rs2        <= enter ? rs2 : '0;
    end
  end

  assign head = sb[0];

  // Scan oldest to youngest so the nearest producer overwrites older matches.
  always_comb begin
    fwd_sel_a = FWD_SEL_W'(FWD_RF);
    fwd_sel_b = FWD_SEL_W'(FWD_RF);
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (ex_rs1 != '0 && sb[k].valid && sb[k].rd == sb_rd_t'(ex_rs1))
        fwd_sel_a = FWD_SEL_W'(k);
      if (ex_rs2 != '0 && sb[k].valid && sb[k].rd == sb_rd_t'(ex_rs2))
        fwd_sel_b = FWD_SEL_W'(k);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit: load-use bubbles, jump/redirect flushes,
// data-memory freeze FSM with watchdog. Perf counters exist only with HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int FWD_STAGES = 2,
  parameter  int MAX_WAIT   = 255,
  localparam int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  decode_valid,
  input  logic [REG_ADDR_W-1:0] decode_rs1,
  input  logic [REG_ADDR_W-1:0] decode_rs2,
  input  logic [REG_ADDR_W-1:0] decode_rd,
  input  logic                  decode_regfile_wr_enable,
  input  logic                  decode_is_load,
  input  logic                  decode_jump,
  input  logic                  execute_redirect,
  input  logic                  mem_dmem_req,
  input  logic                  dmem_ready,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  freeze,
  output logic                  flush_fetch,
  output logic                  flush_execute,
  output logic [FWD_SEL_W-1:0]  fwd_sel_a,
  output logic [FWD_SEL_W-1:0]  fwd_sel_b,
  output logic                  mem_timeout,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  hz_state_t         state;
  hz_state_t         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              load_use;
  logic              enter;
  sb_entry_t         ex_head;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .advance   (!freeze),
    .enter     (enter),
    .rs1       (decode_rs1),
    .rs2       (decode_rs2),
    .rd        (decode_rd),
    .wr_enable (decode_regfile_wr_enable),
    .is_load   (decode_is_load),
    .head      (ex_head),
    .fwd_sel_a (fwd_sel_a),
    .fwd_sel_b (fwd_sel_b)
  );

  assign load_use = ex_head.valid && ex_head.is_load &&
                    (ex_head.rd == sb_rd_t'(decode_rs1) ||
                     ex_head.rd == sb_rd_t'(decode_rs2));

  assign enter = decode_valid && !stall_decode && !flush_execute;

  // The access that starts a wait is frozen in its own RUN cycle, and the
  // cycle that sees dmem_ready already advances, so the freeze window is
  // exactly the cycles the memory stage is stuck.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next    = state;
    waiting       = 1'b0;
    freeze        = 1'b0;
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    flush_fetch   = 1'b0;
    flush_execute = 1'b0;
    case (state)
      RUN:      waiting = mem_dmem_req && !dmem_ready;
      MEM_WAIT: waiting = !dmem_ready;
      default:  waiting = 1'b0;
    endcase
    if (waiting) begin
      state_next   = MEM_WAIT;
      freeze       = 1'b1;
      stall_fetch  = 1'b1;
      stall_decode = 1'b1;
    end else begin
      state_next = RUN;
      if (execute_redirect) begin
        flush_fetch   = 1'b1;
        flush_execute = 1'b1;
      end else if (load_use) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        flush_execute = 1'b1;
      end else if (decode_jump) begin
        // A stalled jump stays in decode and flushes once it is released.
        flush_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (!waiting)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (waiting && wait_cnt >= WAIT_LAST)
        mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_decode && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if ((flush_fetch || flush_execute) && flush_count != '1)
        flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a log-based pipeline model.
module tb_hazard_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_STAGES = 2;
  localparam int MAX_WAIT   = 4;
  localparam int FSW        = 2;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, decode_valid, decode_regfile_wr_enable, decode_is_load;
  logic decode_jump, execute_redirect, mem_dmem_req, dmem_ready;
  logic [REG_ADDR_W-1:0] decode_rs1, decode_rs2, decode_rd;
  logic stall_fetch, stall_decode, freeze, flush_fetch, flush_execute, mem_timeout;
  logic [FSW-1:0] fwd_sel_a, fwd_sel_b;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .decode_valid             (decode_valid),
    .decode_rs1               (decode_rs1),
    .decode_rs2               (decode_rs2),
    .decode_rd                (decode_rd),
    .decode_regfile_wr_enable (decode_regfile_wr_enable),
    .decode_is_load           (decode_is_load),
    .decode_jump              (decode_jump),
    .execute_redirect         (execute_redirect),
    .mem_dmem_req             (mem_dmem_req),
    .dmem_ready               (dmem_ready),
    .stall_fetch              (stall_fetch),
    .stall_decode             (stall_decode),
    .freeze                   (freeze),
    .flush_fetch              (flush_fetch),
    .flush_execute            (flush_execute),
    .fwd_sel_a                (fwd_sel_a),
    .fwd_sel_b                (fwd_sel_b),
    .mem_timeout              (mem_timeout),
    .stall_cycles             (stall_cycles),
    .flush_count              (flush_count)
  );

  typedef struct {
    bit rst, dv, we, ld, jump, redir, req, ready;
    int rs1, rs2, rd;
  } stim_t;

  // One instruction as it entered execute; index k of the log is stage k.
  typedef struct {
    bit prod, ld;
    int rd, rs1, rs2;
  } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  ent_t ex_log[$];
  bit   m_in_wait, m_timeout, m_waiting;
  int   m_frozen;
  int unsigned m_stalls, m_flushes;
  bit   e_freeze, e_stall, e_ff, e_fe;
  int   e_fwd_a, e_fwd_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t stage(input int k);
    ent_t b = '{default: 0};
    if (k < ex_log.size()) return ex_log[k];
    return b;
  endfunction

  function automatic int fwd_src(input int r);
    if (r == 0) return 0;
    for (int k = 1; k <= FWD_STAGES; k++)
      if (stage(k).prod && stage(k).rd == r) return k;
    return 0;
  endfunction

  task automatic model_eval(input stim_t s);
    ent_t e0 = stage(0);
    bit   lu = e0.prod && e0.ld && (e0.rd == s.rs1 || e0.rd == s.rs2);
    m_waiting = m_in_wait ? !s.ready : (s.req && !s.ready);
    e_freeze = 0; e_stall = 0; e_ff = 0; e_fe = 0;
    if (m_waiting) begin
      e_freeze = 1; e_stall = 1;
    end else if (s.redir) begin
      e_ff = 1; e_fe = 1;
    end else if (lu) begin
      e_stall = 1; e_fe = 1;
    end else if (s.jump) begin
      e_ff = 1;
    end
    e_fwd_a = fwd_src(e0.rs1);
    e_fwd_b = fwd_src(e0.rs2);
  endtask

  task automatic model_commit(input stim_t s);
    ent_t e;
    bit   enter;
    if (s.rst) begin
      ex_log.delete();
      m_in_wait = 0; m_timeout = 0; m_frozen = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if (e_stall) m_stalls++;
    if (e_ff || e_fe) m_flushes++;
    if (m_waiting) begin
      m_frozen++;
      if (m_frozen >= MAX_WAIT) m_timeout = 1;
    end else begin
      m_frozen = 0;
      enter = s.dv && !e_stall && !e_fe;
      e.prod = enter && s.we && s.rd != 0;
      e.ld   = enter && s.ld;
      e.rd   = s.rd;
      e.rs1  = enter ? s.rs1 : 0;
      e.rs2  = enter ? s.rs2 : 0;
      ex_log.push_front(e);
      if (ex_log.size() > FWD_STAGES + 1) void'(ex_log.pop_back());
    end
    m_in_wait = m_waiting;
  endtask

  // Drive one cycle, compare every output against the model mid-cycle,
  // then advance the model by the coming clock edge.
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst; decode_valid = s.dv; decode_regfile_wr_enable = s.we;
    decode_is_load = s.ld; decode_jump = s.jump; execute_redirect = s.redir;
    mem_dmem_req = s.req; dmem_ready = s.ready;
    decode_rs1 = 5'(s.rs1); decode_rs2 = 5'(s.rs2); decode_rd = 5'(s.rd);
    #5;
    model_eval(s);
    check("freeze",        32'(freeze),        32'(e_freeze));
    check("stall_fetch",   32'(stall_fetch),   32'(e_stall));
    check("stall_decode",  32'(stall_decode),  32'(e_stall));
    check("flush_fetch",   32'(flush_fetch),   32'(e_ff));
    check("flush_execute", 32'(flush_execute), 32'(e_fe));
    check("fwd_sel_a",     32'(fwd_sel_a),     32'(e_fwd_a));
    check("fwd_sel_b",     32'(fwd_sel_b),     32'(e_fwd_b));
    check("mem_timeout",   32'(mem_timeout),   32'(m_timeout));
    check("stall_cycles",  stall_cycles,       PERF ? m_stalls : 32'd0);
    check("flush_count",   flush_count,        PERF ? m_flushes : 32'd0);
    model_commit(s);
  endtask

  function automatic stim_t idle();
    stim_t s = '{default: 0};
    s.ready = 1;
    return s;
  endfunction

  function automatic stim_t op(input int rd, input int rs1, input int rs2, input bit ld);
    stim_t s = idle();
    s.dv = 1; s.we = 1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.ld = ld;
    return s;
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  initial begin
    stim_t s, r;
    rst = 1; decode_valid = 0; decode_regfile_wr_enable = 0; decode_is_load = 0;
    decode_jump = 0; execute_redirect = 0; mem_dmem_req = 0; dmem_ready = 1;
    decode_rs1 = 0; decode_rs2 = 0; decode_rd = 0;

    s = idle(); s.rst = 1;
    step(s); step(s);
    step(idle());
    check("reset_ctrl", 32'({freeze, stall_fetch, stall_decode, flush_fetch,
                             flush_execute, fwd_sel_a, fwd_sel_b, mem_timeout}), 32'd0);
    check("reset_perf", stall_cycles | flush_count, 32'd0);

    // Forwarding: add x5 ; sub x6,x5,x1, then with one independent op between.
    step(op(5, 1, 2, 0)); step(op(6, 5, 1, 0)); step(idle());
    check("fwd_adjacent_a", 32'(fwd_sel_a), 32'd1);
    check("fwd_adjacent_b", 32'(fwd_sel_b), 32'd0);
    step(op(5, 1, 2, 0)); step(op(9, 1, 2, 0)); step(op(6, 5, 1, 0)); step(idle());
    check("fwd_gap_a", 32'(fwd_sel_a), 32'd2);

    // Load-use: lw x7 ; add x8,x7,x7 -> one bubble, then forward from stage 2.
    drain(3);
    step(op(7, 1, 0, 1));
    step(op(8, 7, 7, 0));
    check("lu_stall_decode", 32'(stall_decode), 32'd1);
    check("lu_stall_fetch", 32'(stall_fetch), 32'd1);
    check("lu_flush_execute", 32'(flush_execute), 32'd1);
    step(op(8, 7, 7, 0));
    check("lu_release", 32'({stall_decode, flush_execute}), 32'd0);
    step(idle());
    check("lu_fwd_a", 32'(fwd_sel_a), 32'd2);
    check("lu_fwd_b", 32'(fwd_sel_b), 32'd2);
    drain(3);
    step(op(0, 1, 0, 1));
    step(op(4, 0, 0, 0));
    check("x0_no_stall", 32'(stall_decode), 32'd0);

    // Redirect overrides a load-use match.
    drain(3);
    step(op(7, 1, 0, 1));
    s = op(8, 7, 1, 0); s.redir = 1;
    step(s);
    check("redir_flush_fetch", 32'(flush_fetch), 32'd1);
    check("redir_flush_execute", 32'(flush_execute), 32'd1);
    check("redir_no_stall", 32'(stall_decode), 32'd0);
    step(idle());
    check("perf_stall_cycles", stall_cycles, PERF ? 32'd1 : 32'd0);
    check("perf_flush_count", flush_count, PERF ? 32'd2 : 32'd0);

    // Memory wait: three frozen cycles with a held jump, released on ready.
    drain(3);
    step(op(5, 1, 2, 0)); step(op(6, 5, 1, 0));
    s = op(1, 0, 0, 0); s.jump = 1; s.req = 1; s.ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(s);
      check("wait_freeze", 32'(freeze), 32'd1);
      check("wait_no_flush", 32'(flush_fetch), 32'd0);
      check("wait_sb_held", 32'(fwd_sel_a), 32'd1);
    end
    s.ready = 1;
    step(s);
    check("wait_exit_freeze", 32'(freeze), 32'd0);
    check("wait_exit_jump", 32'(flush_fetch), 32'd1);
    check("wait_exit_timeout", 32'(mem_timeout), 32'd0);

    // Watchdog: timeout after four frozen cycles, sticky until rst.
    drain(2);
    s = idle(); s.req = 1; s.ready = 0;
    for (int i = 1; i <= 6; i++) begin
      step(s);
      check("wd_timeout", 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
    end
    s.ready = 1;
    step(s);
    check("wd_sticky_exit", 32'(mem_timeout), 32'd1);
    step(idle());
    check("wd_sticky_run", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a memory wait.
    s = idle(); s.req = 1; s.ready = 0;
    step(s); step(s);
    r = s; r.rst = 1;
    step(r);
    step(idle());
    check("rst_wait_ctrl", 32'({freeze, stall_fetch, stall_decode, flush_fetch,
                                flush_execute, fwd_sel_a, fwd_sel_b, mem_timeout}), 32'd0);
    check("rst_wait_perf", stall_cycles | flush_count, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(99) == 0);
      s.dv    = ($urandom_range(9) < 8);
      s.rd    = $urandom_range(7);
      s.rs1   = $urandom_range(7);
      s.rs2   = $urandom_range(7);
      s.we    = ($urandom_range(9) < 7);
      s.ld    = ($urandom_range(9) < 3);
      s.jump  = ($urandom_range(19) == 0);
      if (s.jump) begin
        s.rs1 = 0;
        s.rs2 = 0;
      end
      s.redir = ($urandom_range(11) == 0);
      s.req   = m_in_wait ? 1'b1 : ($urandom_range(4) == 0);
      s.ready = 1'($urandom_range(1));
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the five-stage RV32I core; generalises the fixed jump-only flush wiring into one controller.
- Tracks in-flight destination registers in a scoreboard, generates forwarding selects for execute operands, and inserts load-use bubbles.
- Sequences flushes on jumps and redirects, and freezes the pipeline while a data-memory access waits on a ready handshake.
- Sits beside the stage modules in the core top level; every stall, flush and forward-select input of the stages is driven from here.

Parameters:
- REG_ADDR_W, 5, register address width
- FWD_STAGES, 2, scoreboard stages after execute that can forward (1=memory, 2=writeback, ...)
- MAX_WAIT, 255, frozen-cycle limit before mem_timeout is asserted
- FWD_SEL_W, $clog2(FWD_STAGES+1), width of forward selects (derived localparam; not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- decode_valid  in  1  decode register holds a real instruction
- decode_rs1, decode_rs2  in  REG_ADDR_W  decode source registers
- decode_rd  in  REG_ADDR_W  decode destination register
- decode_regfile_wr_enable  in  1  decode instruction writes rd
- decode_is_load  in  1  decode instruction result source is data memory
- decode_jump  in  1  JAL resolved in decode
- execute_redirect  in  1  taken branch or JALR resolved in execute
- mem_dmem_req  in  1  memory-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- stall_fetch, stall_decode  out  1  hold the PC and the decode register
- freeze  out  1  hold the execute, memory and writeback registers
- flush_fetch  out  1  load a bubble into the decode register
- flush_execute  out  1  load a bubble into the execute register
- fwd_sel_a, fwd_sel_b  out  FWD_SEL_W  execute operand source: 0 = register file, k = scoreboard stage k
- mem_timeout  out  1  sticky memory-wait watchdog flag
- stall_cycles, flush_count  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset: all outputs 0, scoreboard entries invalid, state RUN, wait counter 0.
- Scoreboard per stage k=0..FWD_STAGES (0=execute): valid, rd, is_load. Also ex_rs1 and ex_rs2 for stage 0.
- Advance: when freeze=0, entry k moves to k+1 and the oldest entry drops.
- Entry into stage 0: decode fields when decode_valid, no stall and no flush; otherwise a bubble (valid=0).
- An entry with rd=0 or wr_enable=0 is stored invalid.
- Forwarding (combinational from registered state): fwd_sel_a is the smallest k>=1 with valid[k] and rd[k]==ex_rs1, provided ex_rs1!=0; otherwise 0. fwd_sel_b is the same using ex_rs2. The youngest producer wins.
- Load-use: valid[0] and is_load[0] and rd[0] matches a decode rs gives a one-cycle bubble.
  - stall_fetch=stall_decode=1 and flush_execute=1.
  - Next cycle the load is in stage 1 and the consumer proceeds, forwarding from stage 2.
- decode_jump: flush_fetch=1 for one cycle; the decode instruction proceeds.
- execute_redirect: flush_fetch=1 and flush_execute=1.
  - This overrides a load-use stall: stall outputs are 0 because the consumer is killed.
- FSM:
  - RUN to MEM_WAIT when mem_dmem_req and !dmem_ready.
  - MEM_WAIT to RUN on dmem_ready; the pipeline advances in that same cycle.
- MEM_WAIT outputs: freeze=stall_fetch=stall_decode=1; all flush outputs masked to 0.
  - Pending redirect or jump inputs stay asserted by their stages and take effect on the first unfrozen cycle.
- Simultaneous load-use and MEM_WAIT: freeze dominates. Load-use is re-evaluated after exit.
- Wait counter:
  - Increments each MEM_WAIT cycle; cleared in RUN.
  - Reaching MAX_WAIT sets mem_timeout, which stays set until rst.
  - The counter saturates and the FSM stays in MEM_WAIT.
- rst in any state, including mid-MEM_WAIT, returns to the reset values the next edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with stall_decode=1.
  - flush_count increments on every cycle with flush_fetch=1 or flush_execute=1.
  - Both are 32-bit, saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- hazard_pkg contains:
  - typedef enum {RUN, MEM_WAIT} hz_state_t
  - localparam FWD_RF=0
  - typedef struct sb_entry_t {valid, rd, is_load}
- Sub-module hazard_scoreboard holds the shift register and the forward-select priority logic, parametrised by FWD_STAGES and REG_ADDR_W.
- The FSM, watchdog and counters stay in hazard_ctrl.

Test Plan:
- Forwarding: `add x5` then `sub x6,x5,x1`. Expect fwd_sel_a=1 on the sub's execute cycle. With one independent instruction in between, expect fwd_sel_a=2.
- Load-use: `lw x7` then `add x8,x7,x7`. Expect exactly one cycle of stall_decode=1 and flush_execute=1, then fwd_sel_a=fwd_sel_b=2. Expect x0 as a destination never to forward.
- Redirect priority: execute_redirect=1 in the same cycle as a load-use match. Expect flush_fetch=1, flush_execute=1 and stall_decode=0.
- Memory wait: mem_dmem_req=1 with dmem_ready=0 for 3 cycles. Expect freeze=1 for 3 cycles and the scoreboard unchanged. A decode_jump held during the wait gives flush_fetch=1 on the cycle dmem_ready=1 is seen.
- Watchdog: MAX_WAIT=4 with dmem_ready held 0. Expect mem_timeout=1 after 4 wait cycles; it stays 1 when ready returns and clears only on rst.
- HAZARD_PERF_EN: after test 2 plus one redirect, expect stall_cycles=1 and flush_count=2. Assert rst mid-MEM_WAIT and expect all outputs 0 next cycle.
